// File: rtl/sd_pkg.sv
// Shared signed-digit definitions for the on-line arithmetic chain: digit
// encodings, the converter state type and the two-wire digit decoder.
package sd_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {IDLE, CONV} state_t;

  // Both 00 and 11 mean zero; the result is one-hot {pos,neg} or all zero.
  function automatic logic [1:0] sd_decode(input logic [1:0] pm);
    case (pm)
      SD_POS:  sd_decode = SD_POS;
      SD_NEG:  sd_decode = SD_NEG;
      default: sd_decode = SD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: folds a decoded digit into the (Q, QM) pair
// while keeping QM = Q - 1, so no carry ever has to propagate.
module sd_otf_step
  import sd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   d,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  always_comb begin
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    if (d == SD_POS) begin
      q_nxt  = {q[W-2:0], 1'b1};
      qm_nxt = {q[W-2:0], 1'b0};
    end else if (d == SD_NEG) begin
      q_nxt  = {qm[W-2:0], 1'b1};
      qm_nxt = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_otf_converter.sv
// MSD-first radix-2 signed-digit stream to two's-complement converter.
// N digits in, one (N+1)-bit result out with a single-cycle valid pulse.
module sd_otf_converter
  import sd_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         digit_valid,
  input  logic         d_plus,
  input  logic         d_minus,
  output logic [N:0]   result,
  output logic         out_valid,
  output logic         busy
);

  localparam int W     = N + 1;
  localparam int CNT_W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam bit ONE_DIGIT = (N == 1);

  state_t           state, state_nxt;
  logic [W-1:0]     q, qm, q_in, qm_in, q_nxt, qm_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, adv, finish;
  logic [1:0]       dig;

  assign dig   = sd_decode({d_plus, d_minus});
  // A start digit is applied on top of the initial Q=0, QM=-1 pair in one go.
  assign q_in  = load ? '0 : q;
  assign qm_in = load ? '1 : qm;

  sd_otf_step #(.W(W)) u_step (
    .q      (q_in),
    .qm     (qm_in),
    .d      (dig),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && digit_valid) begin
          load = 1'b1;
          if (ONE_DIGIT) finish = 1'b1;
          else           state_nxt = CONV;
        end
      end
      CONV: begin
        // A new start aborts the operand in flight and restarts from its digit.
        if (start && digit_valid) begin
          load = 1'b1;
        end else if (digit_valid) begin
          adv = 1'b1;
          if (cnt == LAST) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      qm        <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load || adv) begin
        q  <= q_nxt;
        qm <= qm_nxt;
      end
      if (load)     cnt <= CNT_W'(1);
      else if (adv) cnt <= cnt + CNT_W'(1);
      out_valid <= finish;
      if (finish) result <= q_nxt;
      busy <= (state_nxt == CONV);
    end
  end

endmodule

// File: doc/sd_otf_converter.md
# sd_otf_converter

Converts an MSD-first radix-2 signed-digit stream, as produced by the on-line adder's two-wire digit output, into a conventional two's-complement word using on-the-fly conversion. There is no carry-propagate step. It sits at the output end of an on-line arithmetic chain and hands the finished result to ordinary binary logic with a one-cycle valid pulse. It is the reader for the digit streams the on-line adders write.

## Interface

Parameters:
- N, default 8: number of signed digits per operand; result is N+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  marks the first digit of a new operand (MSD); sampled only when digit_valid=1
- digit_valid  input  1  the digit on d_plus/d_minus is present this cycle
- d_plus  input  1  positive half of digit
- d_minus  input  1  negative half of digit; digit value = d_plus − d_minus
- result  output  N+1  two's-complement value Σ d_i·2^(N−i), i=1..N (d_1 = MSD)
- out_valid  output  1  one-cycle pulse; result is valid this cycle and holds afterwards
- busy  output  1  high while a conversion is in progress

## Operation

- Digit decode: {d_plus,d_minus} 10 → +1, 01 → −1, 00 and 11 → 0. Both 0 encodings are legal and equivalent.
- Registers Q and QM are each N+1 bits, with the invariant QM = Q − 1.
- Init on accepted start: Q = 0 and QM = all ones, then the first digit is applied in the same cycle.
- Update per accepted digit d:
  - d=+1: Q ← {Q[N−1:0],1}, QM ← {Q[N−1:0],0}
  - d=0: Q ← {Q[N−1:0],0}, QM ← {QM[N−1:0],1}
  - d=−1: Q ← {QM[N−1:0],1}, QM ← {QM[N−1:0],0}
- Digit counter cnt, width clog2(N+1): cleared to 1 when start is accepted, incremented per accepted digit.
- FSM:
  - IDLE → CONV on start&digit_valid.
  - CONV → IDLE after the N-th digit is accepted. result ← final Q and out_valid=1 on the next cycle.
- Stall: digit_valid=0 in CONV holds Q, QM and cnt. There is no timeout.
- Digits with digit_valid=1 but start=0 in IDLE are ignored.
- start&digit_valid in CONV aborts the current conversion. The partial value is discarded, there is no out_valid for it, and the new conversion begins with this digit.
- Range: −(2^N−1) … +(2^N−1). This always fits in N+1 bits, so there is no overflow condition.

## Timing

- Reset (async assert, sync release): state=IDLE, Q=0, QM=0, cnt=0, result=0, out_valid=0, busy=0.
- Reset mid-conversion: everything returns to the reset values immediately, and no out_valid is produced.
- busy is a registered output. It goes high the cycle after start is accepted. It goes low in the same cycle out_valid goes high.
- Latency: with digits on N consecutive cycles t..t+N−1, out_valid is high at t+N. It is registered and lasts exactly one cycle.
- result changes only on the out_valid cycle (or on reset) and holds between conversions.
- Back-to-back: start&digit_valid is accepted in the out_valid cycle. Throughput is one operand per N cycles with no gap.
- N=1: start&digit_valid at t gives out_valid at t+1.

## Structure

- Shared package sd_pkg:
  - digit encoding localparams SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00
  - state enum {IDLE, CONV}
  - decode function returning a 2-bit one-hot {pos,neg}; the adders' stream generators reuse the same package.
- One sub-module is natural: sd_otf_step. It is combinational, takes (Q, QM, d) and returns the next (Q, QM). This lets the update rule be unit-checked and reused in a future parallel converter. The FSM, counter and output register stay in the top module.

## Test plan

- N=4, digits +1,0,−1,+1 on consecutive cycles with start on the first → result=5'b00111 (7), out_valid one cycle at t+4, busy high t+1..t+3.
- N=4, digits −1,−1,−1,−1 → result=5'b10001 (−15). Digits +1,−1,0,0 → result=5'b00100 (4). Digits 0 encoded as 11,11,11,11 → result=0.
- N=4, digits +1,0,−1,+1 with digit_valid low for 3 cycles after the second digit → same result 7, out_valid delayed by exactly 3 cycles.
- N=4: start plus two digits, then a new start with −1,0,0,0 → no out_valid for the first operand; result=5'b11000 (−8).
- Back-to-back: operand 7, then start on its out_valid cycle with operand −15 → two out_valid pulses 4 cycles apart, results 7 then −15.
- rst_n pulsed low after the second digit → outputs 0 and busy=0 immediately; no out_valid; the next full operand converts correctly.
